dmem_bus_master: RTL and testbench

Data-side bus initiator between the CPU memory stage and the SRAM-like data bus (`data_req`/`data_addr_ok`/`data_data_ok`). Takes one load/store from the memory stage, issues it with the address/data handshake, waits for the response, and returns the sign- or zero-extended load result. Holds the pipeline stalled while the access is outstanding. One outstanding transaction at a time.

---
 rtl/dmem_bus_master.sv | 94 +++++++++
 tb/tb_dmem_bus_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_master.sv
// dmem_bus_master: single-outstanding data bus initiator with load extension and store lane replication.
// DMEM_ALIGN_CHECK_EN enables misaligned-access trapping (mem_adel/mem_ades).
module dmem_bus_master (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic        mem_stall,
   output logic        mem_adel,
   output logic        mem_ades,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic [31:0] data_rdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state;
   logic sgn;
   logic mis;
   logic [31:0] wd, blane, hlane, ext;
   assign mem_stall = mem_req & ~mem_done;
   assign wd = mem_size == 2'd0 ? {4{mem_wdata[7:0]}} : mem_size == 2'd1 ? {2{mem_wdata[15:0]}} : mem_wdata;
   assign blane = data_rdata >> {data_addr[1:0], 3'b000};
   assign hlane = data_rdata >> {data_addr[1], 4'b0000};
   assign ext = data_wr ? 32'd0 :
                data_size == 2'd0 ? {{24{sgn & blane[7]}}, blane[7:0]} :
                data_size == 2'd1 ? {{16{sgn & hlane[15]}}, hlane[15:0]} : data_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
   assign mis = (mem_size == 2'd1 & mem_addr[0]) | (mem_size[1] & |mem_addr[1:0]);
`else
   assign mis = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sgn        <= 1'b0;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= 2'd0;
         data_addr  <= 32'd0;
         data_wdata <= 32'd0;
         mem_rdata  <= 32'd0;
         mem_done   <= 1'b0;
         mem_adel   <= 1'b0;
         mem_ades   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mem_req) begin
               data_wr    <= mem_wr;
               data_size  <= mem_size == 2'd3 ? 2'd2 : mem_size;
               sgn        <= mem_signed;
               data_addr  <= mem_addr;
               data_wdata <= wd;
               // misaligned accesses never reach the bus
               if (mis) begin
                  state     <= DONE;
                  mem_done  <= 1'b1;
                  mem_adel  <= ~mem_wr;
                  mem_ades  <= mem_wr;
                  mem_rdata <= 32'd0;
               end else begin
                  state    <= REQ;
                  data_req <= 1'b1;
               end
            end
            REQ: if (data_addr_ok) begin
               data_req <= 1'b0;
               state    <= WAIT;
            end
            WAIT: if (data_data_ok) begin
               mem_rdata <= ext;
               mem_done  <= 1'b1;
               state     <= DONE;
            end
            default: begin
               mem_done <= 1'b0;
               mem_adel <= 1'b0;
               mem_ades <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_bus_master.sv
// tb_dmem_bus_master: directed checks of dmem_bus_master against a cycle-stepped bus responder.
module tb_dmem_bus_master;
   logic clk = 1'b0, rst = 1'b1;
   logic mem_req = 1'b0, mem_wr = 1'b0, mem_signed = 1'b0;
   logic [1:0] mem_size = 2'd0;
   logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0, data_rdata = 32'd0;
   logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] mem_rdata, data_addr, data_wdata;
   logic mem_done, mem_stall, mem_adel, mem_ades, data_req, data_wr;
   logic [1:0] data_size;
   int errs = 0, checks = 0;
   int dcyc, nreq, nacc;
   logic [31:0] rd;
   logic el, es;
   dmem_bus_master dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
      .mem_adel(mem_adel), .mem_ades(mem_ades), .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data_req"}, {31'd0, data_req}, 32'd0);
      chk({tag, "_data_wr"}, {31'd0, data_wr}, 32'd0);
      chk({tag, "_data_size"}, {30'd0, data_size}, 32'd0);
      chk({tag, "_data_addr"}, data_addr, 32'd0);
      chk({tag, "_data_wdata"}, data_wdata, 32'd0);
      chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
      chk({tag, "_mem_done"}, {31'd0, mem_done}, 32'd0);
      chk({tag, "_adel_ades"}, {30'd0, mem_adel, mem_ades}, 32'd0);
   endtask
   // Cycle 0 is the first cycle mem_req is high; addr_ok is granted after okd waiting
   // cycles of data_req, data_ok arrives d cycles after the accepting cycle.
   task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wdat, input logic [31:0] rword,
                         input int okd, input int d,
                         output int done_c, output int req_n, output int acc_n,
                         output logic [31:0] r, output logic e_l, output logic e_s);
      int acc, unstable, unstall;
      logic [68:0] snap;
      acc = -1; done_c = -1; req_n = 0; acc_n = 0; unstable = 0; unstall = 0;
      snap = '0; r = '0; e_l = 1'b0; e_s = 1'b0;
      @(negedge clk);
      mem_req = 1'b1; mem_wr = wr; mem_size = sz; mem_signed = sg;
      mem_addr = a; mem_wdata = wdat; data_rdata = rword;
      for (int c = 0; c < 40 && done_c < 0; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (data_req) begin
            if (req_n == 0) snap = {data_addr, data_wdata, data_size, data_wr, 2'b00};
            else if (snap !== {data_addr, data_wdata, data_size, data_wr, 2'b00}) unstable++;
            req_n++;
         end
         data_addr_ok = data_req && (req_n > okd);
         if (data_addr_ok) begin
            acc_n++;
            acc = c;
         end
         data_data_ok = (acc >= 0) && (c == acc + d);
         if (mem_done) begin
            done_c = c;
            r = mem_rdata; e_l = mem_adel; e_s = mem_ades;
            chk("stall_at_done", {31'd0, mem_stall}, 32'd0);
         end else if (!mem_stall) unstall++;
      end
      chk("req_stable", unstable, 0);
      chk("stall_held", unstall, 0);
      @(negedge clk);
      mem_req = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      chk("done_pulse", {30'd0, mem_done, data_req}, 32'd0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk_reset_vals("rst");
      rst = 1'b0;
      // word load, immediate addr_ok, D=3
      access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, dcyc, nreq, nacc, rd, el, es);
      chk("wl_latency", dcyc, 5);
      chk("wl_req_cycles", nreq, 1);
      chk("wl_accepts", nacc, 1);
      chk("wl_rdata", rd, 32'hDEADBEEF);
      chk("wl_addr", data_addr, 32'h10);
      // signed byte load from lane 3
      access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF7F01, 0, 3, dcyc, nreq, nacc, rd, el, es);
      chk("sb_rdata", rd, 32'hFFFFFF80);
      chk("sb_size", {30'd0, data_size}, 32'd0);
      // unsigned half load from upper half
      access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h80FF7F01, 0, 3, dcyc, nreq, nacc, rd, el, es);
      chk("uh_rdata", rd, 32'h000080FF);
      // signed half load from lower half
      access(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h12348001, 0, 1, dcyc, nreq, nacc, rd, el, es);
      chk("sh_rdata", rd, 32'hFFFF8001);
      chk("sh_latency", dcyc, 3);
      // unsigned byte load lane 1
      access(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, 32'h11A5C322, 0, 2, dcyc, nreq, nacc, rd, el, es);
      chk("ub_rdata", rd, 32'h000000C3);
      // byte store
      access(1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AB, 32'hFFFFFFFF, 0, 3, dcyc, nreq, nacc, rd, el, es);
      chk("bs_wdata", data_wdata, 32'hABABABAB);
      chk("bs_size_wr", {29'd0, data_size, data_wr}, 32'b001);
      chk("bs_rdata", rd, 32'd0);
      // size 3 word store, addr_ok withheld 4 cycles
      access(1'b1, 2'd3, 1'b0, 32'h44, 32'hCAFE1234, 32'h0, 4, 3, dcyc, nreq, nacc, rd, el, es);
      chk("ws_req_cycles", nreq, 5);
      chk("ws_accepts", nacc, 1);
      chk("ws_latency", dcyc, 9);
      chk("ws_size", {30'd0, data_size}, 32'd2);
      chk("ws_wdata", data_wdata, 32'hCAFE1234);
      // reset pulsed while waiting for the response
      @(negedge clk);
      mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h40; data_rdata = 32'h12345678;
      @(negedge clk);
      #1;
      chk("rw_req", {31'd0, data_req}, 32'd1);
      data_addr_ok = 1'b1;
      @(negedge clk);
      #1;
      data_addr_ok = 1'b0;
      chk("rw_wait", {31'd0, data_req}, 32'd0);
      rst = 1'b1; mem_req = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      chk_reset_vals("rw");
      nreq = 0;
      repeat (5) begin
         @(negedge clk);
         #1;
         nreq += int'(mem_done) + int'(data_req);
      end
      chk("rw_no_done", nreq, 0);
      access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 0, 3, dcyc, nreq, nacc, rd, el, es);
      chk("rw_after_rdata", rd, 32'h0BADF00D);
      chk("rw_after_latency", dcyc, 5);
      // misaligned accesses
      access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 3, dcyc, nreq, nacc, rd, el, es);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("ma_wl_latency", dcyc, 1);
      chk("ma_wl_reqs", nreq, 0);
      chk("ma_wl_adel", {30'd0, el, es}, 32'b10);
      chk("ma_wl_rdata", rd, 32'd0);
`else
      chk("ma_wl_latency", dcyc, 5);
      chk("ma_wl_addr", data_addr, 32'h102);
      chk("ma_wl_adel", {30'd0, el, es}, 32'b00);
      chk("ma_wl_rdata", rd, 32'hCAFEF00D);
`endif
      access(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000BEEF, 32'h0, 0, 3, dcyc, nreq, nacc, rd, el, es);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("ma_hs_reqs", nreq, 0);
      chk("ma_hs_ades", {30'd0, el, es}, 32'b01);
`else
      chk("ma_hs_reqs", nreq, 1);
      chk("ma_hs_ades", {30'd0, el, es}, 32'b00);
      chk("ma_hs_wdata", data_wdata, 32'hBEEFBEEF);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
